// File: rtl/press_decoder.sv
// Push-button event classifier: turns a debounced level into short, long and
// double press strobes, a held flag while a long press persists, and a busy flag.
module press_decoder #(
  parameter int unsigned LONG_CNT = 50_000_000,
  parameter int unsigned GAP_CNT  = 25_000_000,
  parameter int unsigned W        = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StLongHold,
    StGap,
    StPress2
  } state_e;

  localparam logic [W-1:0] CntOne   = W'(1);
  localparam logic [W-1:0] LongLast = W'(LONG_CNT - 1);
  localparam logic [W-1:0] GapLast  = W'(GAP_CNT - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           short_q, short_d;
  logic           long_q, long_d;
  logic           double_q, double_d;
  logic           held_q, held_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  // cnt counts consecutive samples in the current phase; every transition reloads it to 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (level) begin
          state_d = StPress1;
          cnt_d   = CntOne;
        end
      end
      StPress1: begin
        if (!level) begin
          state_d = StGap;
          cnt_d   = CntOne;
        end else if (cnt_q == LongLast) begin
          state_d = StLongHold;
          cnt_d   = CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLongHold: begin
        if (!level) begin
          state_d = StIdle;
          cnt_d   = CntOne;
        end
      end
      StGap: begin
        if (level) begin
          state_d = StPress2;
          cnt_d   = CntOne;
        end else if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPress2: begin
        if (!level) begin
          state_d = StIdle;
          cnt_d   = CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered on the same edge that samples the deciding level.
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    held_d   = held_q;
    case (state_q)
      StPress1: begin
        if (level && (cnt_q == LongLast)) begin
          long_d = 1'b1;
          held_d = 1'b1;
        end
      end
      StLongHold: begin
        if (!level) held_d = 1'b0;
      end
      StGap: begin
        if (level) begin
          double_d = 1'b1;
        end else if (cnt_q == GapLast) begin
          short_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder: expected strobes are queued with the edge they
// must appear on when stimulus is planned, then popped as the DUT emits them.
module tb_press_decoder;

  localparam int unsigned LongCnt = 8;
  localparam int unsigned GapCnt  = 4;
  localparam int unsigned CntW    = 4;

  localparam logic [2:0] KShort  = 3'b001;
  localparam logic [2:0] KLong   = 3'b010;
  localparam logic [2:0] KDouble = 3'b100;

  logic clk = 1'b0;
  logic reset_n;
  logic level;
  logic short_press, long_press, double_press, held, busy;

  press_decoder #(
    .LONG_CNT (LongCnt),
    .GAP_CNT  (GapCnt),
    .W        (CntW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .level        (level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [2:0]  kind;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned edge_n = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int unsigned at, input logic [2:0] kind);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    logic [2:0] strobes;
    ev_t        e;
    strobes = {double_press, long_press, short_press};
    chk("onehot_strobes", 32'($onehot0(strobes)), 32'd1);
    if (strobes != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(strobes), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_edge", edge_n, e.at);
        chk("strobe_kind", 32'(strobes), 32'(e.kind));
      end
    end else if (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
      e = exp_q.pop_front();
      chk("missed_strobe", 32'(strobes), 32'(e.kind));
    end
  endtask

  // One sampling edge with the given level, then observe what that edge produced.
  task automatic drive(input logic lv);
    level = lv;
    @(posedge clk);
    edge_n++;
    #1;
    monitor();
  endtask

  task automatic run(input logic lv, input int n);
    for (int i = 0; i < n; i++) drive(lv);
  endtask

  initial begin
    level   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({short_press, long_press, double_press, held, busy}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(i[0]);
      chk("reset_hold", 32'({short_press, long_press, double_press, held, busy}), 32'd0);
    end

    // Release with level high: fresh press, 3 samples, then short press.
    reset_n = 1'b1;
    k = edge_n + 1;
    expect_ev(k + 6, KShort);
    drive(1'b1);
    chk("busy_after_release", 32'(busy), 32'd1);
    run(1'b1, 2);
    run(1'b0, 4);
    chk("short_busy_low", 32'(busy), 32'd0);
    run(1'b0, 2);

    // Long press of 12 samples.
    k = edge_n + 1;
    expect_ev(k + 7, KLong);
    run(1'b1, 7);
    chk("held_before_long", 32'(held), 32'd0);
    drive(1'b1);
    chk("held_at_long", 32'(held), 32'd1);
    run(1'b1, 4);
    chk("held_during_hold", 32'(held), 32'd1);
    chk("busy_during_hold", 32'(busy), 32'd1);
    drive(1'b0);
    chk("held_after_release", 32'(held), 32'd0);
    chk("busy_after_long", 32'(busy), 32'd0);
    run(1'b0, 6);

    // 7-sample press is short.
    k = edge_n + 1;
    expect_ev(k + 10, KShort);
    run(1'b1, 7);
    run(1'b0, 4);
    chk("busy_after_7", 32'(busy), 32'd0);
    run(1'b0, 1);

    // 8-sample press is long.
    k = edge_n + 1;
    expect_ev(k + 7, KLong);
    run(1'b1, 8);
    run(1'b0, 3);

    // Gap of 3 lows then high: rises on the would-be short edge, double wins.
    k = edge_n + 1;
    expect_ev(k + 5, KDouble);
    run(1'b1, 2);
    run(1'b0, 3);
    drive(1'b1);
    chk("busy_in_press2", 32'(busy), 32'd1);
    drive(1'b1);
    drive(1'b0);
    chk("busy_after_gap3", 32'(busy), 32'd0);
    run(1'b0, 2);

    // Gap of 4 lows: short, then next high is a fresh press.
    k = edge_n + 1;
    expect_ev(k + 5, KShort);
    run(1'b1, 2);
    run(1'b0, 4);
    chk("busy_after_gap4", 32'(busy), 32'd0);
    k = edge_n + 1;
    expect_ev(k + 4, KShort);
    drive(1'b1);
    chk("busy_fresh_press", 32'(busy), 32'd1);
    run(1'b0, 4);
    chk("busy_after_fresh", 32'(busy), 32'd0);
    run(1'b0, 1);

    // Double press: high 2, low 2, high 5, low.
    k = edge_n + 1;
    expect_ev(k + 4, KDouble);
    run(1'b1, 2);
    run(1'b0, 2);
    run(1'b1, 5);
    drive(1'b0);
    chk("busy_after_double", 32'(busy), 32'd0);
    run(1'b0, 10);

    // Reset in GAP: the pending short press must never appear.
    run(1'b1, 2);
    run(1'b0, 2);
    chk("busy_in_gap", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_gap", 32'({short_press, long_press, double_press, held, busy}), 32'd0);
    run(1'b0, 2);
    reset_n = 1'b1;
    run(1'b0, 8);
    chk("busy_after_gap_reset", 32'(busy), 32'd0);
    chk("held_after_gap_reset", 32'(held), 32'd0);

    // Reset during a long hold clears held immediately.
    k = edge_n + 1;
    expect_ev(k + 7, KLong);
    run(1'b1, 9);
    chk("held_before_reset", 32'(held), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_held", 32'({short_press, long_press, double_press, held, busy}), 32'd0);
    level   = 1'b0;
    reset_n = 1'b1;
    run(1'b0, 4);
    chk("busy_after_hold_reset", 32'(busy), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
